// File: rtl/out_channel_reader.sv
`default_nettype none
// ============================================================================
// Module   : out_channel_reader
// Purpose  : Consumer end of the interpreter's output channel. The `out`
//            instruction pushes one element per cycle into a circular store
//            (never stalled). Stored elements are presented oldest-first on a
//            valid/ready stream. Occupancy, total writes and a sticky
//            overflow flag are reported.
// Ports    : clock, reset (async, active-high), clear (sync flush)
//            out_write/out_data       - producer strobe and element
//            read_valid/read_ready    - head handshake
//            read_data                - head (oldest) element
//            count                    - elements held, 0..N_OUT
//            overflow                 - sticky, unread element overwritten
//            written                  - total write strobes (mod 2^32)
// Revision : 1.0 - initial release
// ============================================================================
module out_channel_reader #(
    parameter int MEMORY_ELEMENT_WIDTH = 12,
    parameter int N_OUT                = 2000,
    parameter int COUNT_WIDTH          = 12
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            out_write,
    input  logic [MEMORY_ELEMENT_WIDTH-1:0] out_data,
    output logic                            read_valid,
    input  logic                            read_ready,
    output logic [MEMORY_ELEMENT_WIDTH-1:0] read_data,
    output logic [COUNT_WIDTH-1:0]          count,
    output logic                            overflow,
    output logic [31:0]                     written
);

    localparam int c_ptr_w = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic [MEMORY_ELEMENT_WIDTH-1:0] r_mem [N_OUT];
    logic [c_ptr_w-1:0]              r_wp;
    logic [c_ptr_w-1:0]              r_rp;
    logic [COUNT_WIDTH-1:0]          r_count;
    logic                            r_overflow;
    logic [31:0]                     r_written;

    logic w_full;
    logic w_rd;
    logic w_wr_full;

    // Wrap at N_OUT-1 so non-power-of-two capacities work.
    function automatic logic [c_ptr_w-1:0] f_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(N_OUT - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign w_full    = (r_count == COUNT_WIDTH'(N_OUT));
    assign w_rd      = read_valid && read_ready;
    // A write into a full store with no read displaces the oldest element.
    assign w_wr_full = out_write && w_full && !w_rd;

    assign read_valid = (r_count != '0);
    assign read_data  = r_mem[r_rp];
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign written    = r_written;

    // Store contents are deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (out_write && !clear) begin
            r_mem[r_wp] <= out_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_written  <= '0;
        end else if (clear) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_written  <= '0;
        end else begin
            if (out_write) begin
                r_wp      <= f_inc(r_wp);
                r_written <= r_written + 32'd1;
            end
            if (w_rd || w_wr_full) begin
                r_rp <= f_inc(r_rp);
            end
            if (w_wr_full) begin
                r_overflow <= 1'b1;
            end
            // Count only moves when exactly one side acts; a write into a
            // full store with no read keeps it pinned at N_OUT.
            if (out_write && !w_rd && !w_full) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end else if (!out_write && w_rd) begin
                r_count <= r_count - COUNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_out_channel_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_channel_reader
// Purpose  : Directed self-checking bench for out_channel_reader with a
//            four-element store.
// Revision : 1.0 - initial release
// ============================================================================
module tb_out_channel_reader;

    localparam int c_w     = 12;
    localparam int c_n     = 4;
    localparam int c_cw    = 12;

    logic            clock;
    logic            reset;
    logic            clear;
    logic            out_write;
    logic [c_w-1:0]  out_data;
    logic            read_valid;
    logic            read_ready;
    logic [c_w-1:0]  read_data;
    logic [c_cw-1:0] count;
    logic            overflow;
    logic [31:0]     written;

    int tests_run;
    int tests_failed;

    out_channel_reader #(
        .MEMORY_ELEMENT_WIDTH (c_w),
        .N_OUT                (c_n),
        .COUNT_WIDTH          (c_cw)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .out_write  (out_write),
        .out_data   (out_data),
        .read_valid (read_valid),
        .read_ready (read_ready),
        .read_data  (read_data),
        .count      (count),
        .overflow   (overflow),
        .written    (written)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [c_w-1:0] d, input logic rdy);
        out_write  = 1'b1;
        out_data   = d;
        read_ready = rdy;
        step();
        out_write  = 1'b0;
        read_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_seq[$];
        tests_run    = 0;
        tests_failed = 0;
        reset      = 1'b1;
        clear      = 1'b0;
        out_write  = 1'b0;
        out_data   = '0;
        read_ready = 1'b0;
        #2;
        check("rst_valid", read_valid, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_written", written, 0);
        step();
        reset = 1'b0;
        step();

        // 1: write 1,2 with ready held high
        out_write = 1'b1; out_data = 1; read_ready = 1'b1;
        check("t1_valid_before", read_valid, 0);
        step();
        check("t1_valid_after", read_valid, 1);
        check("t1_head1", read_data, 1);
        out_data = 2;
        step();
        check("t1_head2", read_data, 2);
        check("t1_count_mid", count, 1);
        out_write = 1'b0;
        step();
        read_ready = 1'b0;
        check("t1_count_end", count, 0);
        check("t1_valid_end", read_valid, 0);
        check("t1_written", written, 2);
        check("t1_ovf", overflow, 0);

        // 2: fill, then overflow
        for (int i = 5; i <= 8; i++) wr(c_w'(i), 1'b0);
        check("t2_count_full", count, 4);
        check("t2_head", read_data, 5);
        check("t2_ovf_before", overflow, 0);
        wr(9, 1'b0);
        check("t2_count_ovf", count, 4);
        check("t2_ovf", overflow, 1);
        exp_seq = '{6, 7, 8, 9};
        read_ready = 1'b1;
        foreach (exp_seq[i]) begin
            check("t2_drain", read_data, 32'(exp_seq[i]));
            step();
        end
        read_ready = 1'b0;
        check("t2_count_end", count, 0);
        check("t2_written", written, 7);
        check("t2_ovf_sticky", overflow, 1);

        // 3: clear, then write+read on a full store and wrap pointers
        clear = 1'b1; step(); clear = 1'b0;
        check("t3_clr_ovf", overflow, 0);
        check("t3_clr_written", written, 0);
        for (int i = 1; i <= 4; i++) wr(c_w'(i), 1'b0);
        check("t3_head_full", read_data, 1);
        wr(10, 1'b1);
        check("t3_count", count, 4);
        check("t3_ovf", overflow, 0);
        exp_seq = '{2, 3, 4, 10, 11, 12, 13};
        for (int i = 0; i < 7; i++) begin
            check("t3_pair_head", read_data, 32'(exp_seq[i]));
            wr(c_w'(11 + i), 1'b1);
            check("t3_pair_count", count, 4);
        end
        exp_seq = '{14, 15, 16, 17};
        read_ready = 1'b1;
        foreach (exp_seq[i]) begin
            check("t3_drain", read_data, 32'(exp_seq[i]));
            step();
        end
        read_ready = 1'b0;
        check("t3_count_end", count, 0);
        check("t3_ovf_end", overflow, 0);
        check("t3_written", written, 12);

        // 4: write and ready on an empty store -- no bypass
        out_write = 1'b1; out_data = 3; read_ready = 1'b1;
        check("t4_valid_same", read_valid, 0);
        step();
        out_write = 1'b0; read_ready = 1'b0;
        check("t4_valid", read_valid, 1);
        check("t4_data", read_data, 3);
        check("t4_count", count, 1);

        // 5: clear beats a simultaneous write and read
        for (int i = 4; i <= 7; i++) wr(c_w'(i), 1'b0);
        check("t5_ovf_set", overflow, 1);
        read_ready = 1'b1; step(); step(); read_ready = 1'b0;
        check("t5_count2", count, 2);
        check("t5_head", read_data, 6);
        clear = 1'b1; out_write = 1'b1; out_data = 7; read_ready = 1'b1;
        step();
        clear = 1'b0; out_write = 1'b0; read_ready = 1'b0;
        check("t5_count", count, 0);
        check("t5_valid", read_valid, 0);
        check("t5_ovf", overflow, 0);
        check("t5_written", written, 0);

        // 6: asynchronous reset mid-drain
        for (int i = 1; i <= 4; i++) wr(c_w'(i), 1'b0);
        wr(5, 1'b0);
        check("t6_ovf_pre", overflow, 1);
        read_ready = 1'b1; step();
        check("t6_count3", count, 3);
        #3;
        reset = 1'b1;
        #1;
        check("t6_async_valid", read_valid, 0);
        check("t6_async_count", count, 0);
        check("t6_async_ovf", overflow, 0);
        check("t6_async_written", written, 0);
        read_ready = 1'b0;
        step();
        reset = 1'b0;
        read_ready = 1'b1; out_write = 1'b1; out_data = 1;
        step();
        check("t6_head1", read_data, 1);
        out_data = 2;
        step();
        out_write = 1'b0;
        check("t6_head2", read_data, 2);
        step();
        read_ready = 1'b0;
        check("t6_count_end", count, 0);
        check("t6_written", written, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/out_channel_reader.md
Name: out_channel_reader

Overview:
- Consumer end of the interpreter's output channel.
- The interpreter's `out` instruction pushes one memory element per cycle into this block's circular store. It never stalls.
- The block presents the stored elements, oldest first, on a valid/ready stream, so a host or test checker can drain program output while the program runs.
- It also reports occupancy, total words written and a sticky overflow flag.

Parameters:
- MemoryElementWidth, 12, width of one channel element.
- NOut, 2000, capacity of the circular store in elements; must be ≥ 2.
- CountWidth, 12, width of the `count` port; must satisfy 2^CountWidth > NOut.

Ports:
- clock, input, 1, sole clock; rising edge active.
- reset, input, 1, asynchronous active-high reset.
- clear, input, 1, synchronous flush of the store and flags.
- out_write, input, 1, interpreter `out` strobe; one element per cycle when high.
- out_data, input, MemoryElementWidth, element written when `out_write` is high.
- read_valid, output, 1, head element is available.
- read_ready, input, 1, consumer accepts the head this cycle.
- read_data, output, MemoryElementWidth, head (oldest) element; meaningful only when `read_valid` is high.
- count, output, CountWidth, elements currently held, 0..NOut.
- overflow, output, 1, sticky; set when an unread element was overwritten.
- written, output, 32, total `out_write` strobes since reset or clear; wraps modulo 2^32.

Behaviour:

Reset (asynchronous; takes effect immediately, including mid-stream):
- Write pointer, read pointer and `count` go to 0.
- `read_valid` = 0, `overflow` = 0, `written` = 0.
- Store contents are not cleared.
- `read_data` is undefined while `read_valid` = 0.

Pointers:
- Write pointer `wp` and read pointer `rp` both range 0..NOut-1.
- Each advances as (p+1) % NOut; wrap occurs at NOut-1 → 0.

Read side:
- `read_valid` = (`count` != 0).
- `read_data` = store[`rp`], combinational from the registered `rp` and the store.
- A transfer occurs on a rising edge where `read_valid` && `read_ready`.
- On a transfer, `rp` advances and `count` decrements.

Write side:
- On a rising edge with `out_write` = 1, store[`wp`] <= `out_data`, `wp` advances and `written` increments.
- Writes are never refused.

Latency:
- An element written at edge N is visible at the head from edge N+1 onward when the store was empty.
- There is no same-cycle bypass. If the store is empty, `read_valid` is 0 in the write cycle even if `read_ready` is 1.

Simultaneous events, evaluated per edge with c = `count` before the edge:
- Write only, c < NOut: `count` = c+1.
- Write only, c == NOut (full): the oldest element is overwritten. `rp` advances together with `wp`, `count` stays NOut, and `overflow` <= 1.
- Read only: `count` = c-1.
- Write and read with c ≥ 1: head consumed and new element stored. `count` unchanged; no overflow, even when full.
- Write and read with c == 0: no transfer; behaves as write only.
- `clear` = 1: `wp`, `rp`, `count`, `overflow` and `written` all go to 0.
  - `clear` has priority over a simultaneous write and read; both are discarded.
  - `written` does not count the discarded write.

Other rules:
- `overflow` stays set until reset or `clear`.
- `count` never exceeds NOut and never underflows.
- `read_ready` while `read_valid` = 0 has no effect.
- No state machine beyond the pointers and counter. Capacity checks use `count`, not pointer comparison, so full and empty are unambiguous.

Test Plan:
1. NOut=4. Reset; write 1 then 2 on consecutive cycles; hold `read_ready` high. Required: `read_valid` rises one cycle after the first write; reads 1 then 2; `count` ends 0; `written` = 2; `overflow` = 0.
2. NOut=4, `read_ready` low. Write 5,6,7,8. Required: `count` = 4, head 5. Write 9 with no read: `count` stays 4, `overflow` = 1, drain yields 6,7,8,9.
3. NOut=4, full with 1..4. Write 10 with `read_ready` = 1 on the same edge. Required: 1 read out, `count` stays 4, `overflow` = 0. Then 7 further write/read pairs wrap both pointers; the drained sequence is the contiguous input order.
4. Empty store; `out_write` = 1 with data 3 and `read_ready` = 1 on the same edge. Required: no transfer that cycle; next cycle `read_valid` = 1, `read_data` = 3, `count` = 1.
5. Store holding 2 elements with `overflow` = 1. Assert `clear` together with a write of 7 and `read_ready` = 1. Required: next cycle `count` = 0, `read_valid` = 0, `overflow` = 0, `written` = 0.
6. Reset asserted asynchronously mid-drain (between edges) with `count` = 3. Required: `read_valid`, `count`, `overflow` and `written` drop to 0 before the next edge. After release, a write of 1 then 2 drains as 1, 2.
